divider8by4_seq: RTL

- Sequential restoring divider; the inverse of the team's combinational 4x4 array multiplier: recovers a factor from an 8-bit product.
- Divides an 8-bit dividend by a 4-bit divisor over 8 iterations, one quotient bit per clock.
- Returns a full 8-bit quotient and a 4-bit remainder using a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath; multiply-then-divide round-trip checks pair the two blocks.

---
 rtl/divider8by4_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/divider8by4_seq.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor,
// one quotient bit per clock, start/busy/done handshake with registered results.
module divider8by4_seq #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    // Handshake: start is accepted on an edge where the FSM is in IDLE or FIN;
    // busy is high in every cycle of an accepted nonzero-divisor operation, and
    // done is a one-cycle pulse in the FIN cycle, with results valid in that cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DIVISOR_W-1:0]    prem_q;
    logic [DIVIDEND_W-1:0]   wdvd_q;
    logic [DIVISOR_W-1:0]    dvs_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    div_zero_q;
    logic [DIVIDEND_W-1:0]   quot_q;
    logic [DIVISOR_W-1:0]    rem_q;

    logic [DIVISOR_W:0]      shifted_d;
    logic [DIVISOR_W:0]      trial_d;
    logic [DIVISOR_W-1:0]    prem_d;
    logic                    qbit_d;

    // The stored partial remainder is always below the divisor, so it fits in
    // DIVISOR_W bits; the shift and trial subtraction use the extra bit.
    always_comb begin
        shifted_d = {prem_q, wdvd_q[DIVIDEND_W-1]};
        trial_d   = shifted_d - {1'b0, dvs_q};
        qbit_d    = ~trial_d[DIVISOR_W];
        prem_d    = qbit_d ? trial_d[DIVISOR_W-1:0] : shifted_d[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prem_q     <= '0;
            wdvd_q     <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FIN: begin
                    if (start) begin
                        wdvd_q <= dividend;
                        dvs_q  <= divisor;
                        prem_q <= '0;
                        cnt_q  <= '0;
                        if (divisor != '0) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q    <= FIN;
                            done_q     <= 1'b1;
                            quot_q     <= '1;
                            rem_q      <= '0;
                            div_zero_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    wdvd_q <= {wdvd_q[DIVIDEND_W-2:0], qbit_d};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        quot_q     <= {wdvd_q[DIVIDEND_W-2:0], qbit_d};
                        rem_q      <= prem_d;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = div_zero_q;
    assign dbg_state = state_q;

endmodule
